pattern_match_engine: RTL and testbench

PATTERN_MATCH_ENGINE -- requirements
Module: pattern_match_engine

---
 rtl/pattern_match_engine.sv | 127 ++++++++++++
 tb/tb_pattern_match_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_match_engine.sv
// pattern_match_engine: streaming multi-slot byte pattern matcher with a two-stage pipeline.
// Define PATTERN_MATCH_ENGINE_COUNT_EN to build the saturating match_count counter.
module pattern_match_engine #(
    parameter int DATA_BYTES   = 4,
    parameter int PAT_BYTES    = 4,
    parameter int NUM_PATTERNS = 4,
    localparam int AW = NUM_PATTERNS > 1 ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    data_valid,
    input  logic [8*DATA_BYTES-1:0] data_in,
    input  logic                    pat_wr_en,
    input  logic [AW-1:0]           pat_wr_addr,
    input  logic [8*PAT_BYTES-1:0]  pat_wr_data,
    input  logic                    pat_dis,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic                    data_out_valid,
    output logic                    match_pulse,
    output logic [NUM_PATTERNS-1:0] match_vec,
    output logic                    match,
    output logic [AW-1:0]           match_idx,
    output logic [15:0]             match_count
);
    localparam int HB = PAT_BYTES > 1 ? PAT_BYTES - 1 : 1;
    localparam int WB = PAT_BYTES - 1 + DATA_BYTES;
    localparam int FW = $clog2(PAT_BYTES + 1);

    logic [NUM_PATTERNS-1:0][8*PAT_BYTES-1:0] pat;
    logic [NUM_PATTERNS-1:0]                  pat_valid;
    logic [NUM_PATTERNS-1:0]                  wr_mask;
    logic [NUM_PATTERNS-1:0]                  hit;
    logic [HB-1:0][7:0]                       hist;
    logic [HB-1:0][7:0]                       hist_nxt;
    logic [WB-1:0][7:0]                       win;
    logic [DATA_BYTES-1:0][8*PAT_BYTES-1:0]   cand;
    logic [DATA_BYTES-1:0]                    elig;
    logic [FW-1:0]                            fill;
    logic [FW-1:0]                            fill_nxt;
    logic [8*DATA_BYTES-1:0]                  s1_data;
    logic                                     s1_valid;
    logic [AW-1:0]                            idx;

    // win[0] is the earliest byte: history first, then the stage-1 word MSB-first
    always_comb begin
        win = '0;
        hist_nxt = hist;
        cand = '0;
        elig = '0;
        for (int j = 0; j < PAT_BYTES - 1; j++) win[j] = hist[j];
        for (int m = 0; m < DATA_BYTES; m++) win[PAT_BYTES-1+m] = s1_data[8*(DATA_BYTES-1-m) +: 8];
        for (int j = 0; j < PAT_BYTES - 1; j++) hist_nxt[j] = win[DATA_BYTES+j];
        for (int k = 0; k < DATA_BYTES; k++) begin
            elig[k] = int'(fill) + k + 1 >= PAT_BYTES;
            for (int b = 0; b < PAT_BYTES; b++) cand[k][8*(PAT_BYTES-1-b) +: 8] = win[k+b];
        end
    end

    assign fill_nxt = int'(fill) + DATA_BYTES >= PAT_BYTES ? FW'(PAT_BYTES) : FW'(int'(fill) + DATA_BYTES);

    // a slot being rewritten this edge drops its hit
    always_comb begin
        wr_mask = '0;
        hit = '0;
        idx = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            wr_mask[i] = pat_wr_en && pat_wr_addr == AW'(i);
            for (int k = 0; k < DATA_BYTES; k++)
                if (s1_valid && pat_valid[i] && elig[k] && cand[k] == pat[i] && !wr_mask[i]) hit[i] = 1'b1;
        end
        for (int i = NUM_PATTERNS - 1; i >= 0; i--) if (hit[i]) idx = AW'(i);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pat <= '0;
            pat_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_PATTERNS; i++) begin
                if (wr_mask[i]) begin
                    pat_valid[i] <= !pat_dis;
                    if (!pat_dis) pat[i] <= pat_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            s1_valid <= 1'b0;
            s1_data <= '0;
            hist <= '0;
            fill <= '0;
            data_out <= '0;
            data_out_valid <= 1'b0;
            match_pulse <= 1'b0;
            match_idx <= '0;
            match_vec <= '0;
        end else begin
            s1_valid <= data_valid;
            if (data_valid) s1_data <= data_in;
            data_out_valid <= s1_valid;
            match_pulse <= |hit;
            match_idx <= idx;
            match_vec <= (match_vec | hit) & ~wr_mask;
            if (s1_valid) begin
                data_out <= s1_data;
                hist <= hist_nxt;
                fill <= fill_nxt;
            end
        end
    end

    assign match = |match_vec;

`ifdef PATTERN_MATCH_ENGINE_COUNT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
        if (!n_rst || clear) cnt <= '0;
        else if (|hit && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign match_count = cnt;
`else
    assign match_count = '0;
`endif
endmodule

// File: tb/tb_pattern_match_engine.sv
// tb_pattern_match_engine: randomized scoreboard bench with a byte-stream reference model.
module tb_pattern_match_engine;
    localparam int DB = 4, PB = 4, NP = 4;

    logic            clk = 1'b0, n_rst = 1'b0, clear = 1'b0, data_valid = 1'b0;
    logic            pat_wr_en = 1'b0, pat_dis = 1'b0;
    logic [8*DB-1:0] data_in = '0;
    logic [1:0]      pat_wr_addr = '0;
    logic [8*PB-1:0] pat_wr_data = '0;
    logic [8*DB-1:0] data_out;
    logic            data_out_valid, match_pulse, match;
    logic [NP-1:0]   match_vec;
    logic [1:0]      match_idx;
    logic [15:0]     match_count;

    typedef struct {
        logic [8*DB-1:0] d;
        logic            p;
        logic [1:0]      idx;
        logic [NP-1:0]   vec;
        logic [15:0]     cnt;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    logic [8*PB-1:0] pat_m[NP];
    logic [NP-1:0]   val_m = '0, vec_m = '0;
    logic [15:0]     cnt_m = '0;
    logic [7:0]      stream_q[$];
    int              tot = 0;
    int              checks = 0, errors = 0;
    int              r;

    pattern_match_engine #(.DATA_BYTES(DB), .PAT_BYTES(PB), .NUM_PATTERNS(NP)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .data_valid(data_valid), .data_in(data_in),
        .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data), .pat_dis(pat_dis),
        .data_out(data_out), .data_out_valid(data_out_valid), .match_pulse(match_pulse),
        .match_vec(match_vec), .match(match), .match_idx(match_idx), .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        stream_q.delete();
        tot = 0;
        vec_m = '0;
        cnt_m = '0;
    endtask

    // reference: scan every PB-byte run of the stream that ends inside this beat
    task automatic model_beat(input logic [8*DB-1:0] d);
        exp_t e;
        logic [NP-1:0] h;
        h = '0;
        for (int k = 0; k < DB; k++) stream_q.push_back(d[8*(DB-1-k) +: 8]);
        for (int i = 0; i < NP; i++) begin
            for (int k = 0; k < DB; k++) begin
                int endpos;
                logic [8*PB-1:0] c;
                endpos = stream_q.size() - DB + k;
                if (val_m[i] && tot + k + 1 >= PB) begin
                    for (int b = 0; b < PB; b++) c[8*(PB-1-b) +: 8] = stream_q[endpos-PB+1+b];
                    if (c == pat_m[i]) h[i] = 1'b1;
                end
            end
        end
        tot += DB;
        while (stream_q.size() > PB - 1) void'(stream_q.pop_front());
        e.d = d;
        e.p = |h;
        e.idx = 2'd0;
        for (int i = NP - 1; i >= 0; i--) if (h[i]) e.idx = 2'(i);
        vec_m = vec_m | h;
`ifdef PATTERN_MATCH_ENGINE_COUNT_EN
        if (e.p && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
        e.vec = vec_m;
        e.cnt = cnt_m;
        sb.push_back(e);
    endtask

    task automatic beat(input logic [8*DB-1:0] d, input bit cl = 1'b0);
        data_valid = 1'b1;
        data_in = d;
        clear = cl;
        if (cl) model_clear();
        else model_beat(d);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        clear = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [8*PB-1:0] d, input bit dis, input bit cl = 1'b0);
        pat_wr_en = 1'b1;
        pat_wr_addr = a;
        pat_wr_data = d;
        pat_dis = dis;
        clear = cl;
        if (cl) model_clear();
        if (a < NP) begin
            if (!dis) pat_m[a] = d;
            val_m[a] = !dis;
            vec_m[a] = 1'b0;
        end
        @(posedge clk);
        #1;
        pat_wr_en = 1'b0;
        pat_dis = 1'b0;
        clear = 1'b0;
    endtask

    task automatic rst();
        n_rst = 1'b0;
        sb.delete();
        for (int i = 0; i < NP; i++) pat_m[i] = '0;
        val_m = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = $urandom_range(0, 1) ? 8'hAA : 8'h55;
        return w;
    endfunction

    always @(negedge clk) begin
        if (data_out_valid) begin
            if (sb.size() == 0) chk("unexpected_out", data_out_valid, 0);
            else begin
                mon_e = sb.pop_front();
                chk("data_out", data_out, mon_e.d);
                chk("match_pulse", match_pulse, mon_e.p);
                chk("match_idx", match_idx, mon_e.idx);
                chk("match_vec", match_vec, mon_e.vec);
                chk("match", match, |mon_e.vec);
                chk("match_count", match_count, mon_e.cnt);
            end
        end else begin
            chk("idle_pulse", match_pulse, 0);
            chk("idle_idx", match_idx, 0);
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst();
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_pulse", match_pulse, 0);
        chk("rst_vec", match_vec, 0);
        chk("rst_match", match, 0);
        chk("rst_idx", match_idx, 0);
        chk("rst_count", match_count, 0);

        // aligned match and exact two-cycle latency
        wr(2'd0, 32'hC0A80001, 1'b0);
        beat(32'hC0A80001);
        @(negedge clk);
        chk("lat1_valid", data_out_valid, 0);
        @(negedge clk);
        chk("lat2_valid", data_out_valid, 1);
        chk("lat2_pulse", match_pulse, 1);
        chk("lat2_data", data_out, 32'hC0A80001);
        idle(3);

        // split across two beats
        clr();
        beat(32'h1122C0A8);
        beat(32'h00013344);
        idle(3);

        // fill gating with an all-zero pattern
        rst();
        wr(2'd0, 32'h00000000, 1'b0);
        beat(32'h00000000);
        beat(32'h00000000);
        idle(3);

        // simultaneous hits on two slots across a beat boundary
        rst();
        wr(2'd1, 32'hC0A80001, 1'b0);
        wr(2'd2, 32'hA8000133, 1'b0);
        beat(32'hC0A80001);
        beat({8'h33, 24'($urandom)});
        idle(3);
        chk("sim_vec", match_vec, 4'b0110);

        // clear coinciding with a matching beat, then disable
        rst();
        wr(2'd0, 32'hC0A80001, 1'b0);
        beat(32'hC0A80001, 1'b1);
        idle(3);
        chk("clr_match", match, 0);
        beat(32'hC0A80001);
        idle(3);
        wr(2'd0, 32'h0, 1'b1);
        chk("dis_vec", match_vec, 0);
        beat(32'hC0A80001);
        idle(3);
        wr(2'd3, 32'h00013344, 1'b0, 1'b1);
        beat(32'h11C0A800);
        beat(32'h01334400);
        idle(3);

        // reset while a matching beat is in flight
        wr(2'd3, 32'hC0A80001, 1'b0);
        beat(32'hC0A80001);
        rst();
        chk("midrst_valid", data_out_valid, 0);
        chk("midrst_pulse", match_pulse, 0);
        idle(3);

        // randomized stream with occasional writes and clears
        for (int i = 0; i < NP; i++) wr(2'(i), rnd_word(), 1'b0);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) beat(rnd_word());
            else if (r < 94) idle(1);
            else if (r < 98) begin
                idle(3);
                wr(2'($urandom_range(0, 3)), rnd_word(), $urandom_range(0, 3) == 0);
            end else begin
                idle(3);
                clr();
            end
        end
        idle(3);

        // counter saturation
        rst();
        wr(2'd0, 32'h0, 1'b0);
`ifdef PATTERN_MATCH_ENGINE_COUNT_EN
        repeat (65537) beat(32'h0);
        idle(3);
        chk("count_final", match_count, 16'hFFFF);
`else
        repeat (100) beat(32'h0);
        idle(3);
        chk("count_final", match_count, 0);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
